// File: rtl/solution_framer_if.sv
// Solver-to-framer capture port plus the framer-to-uart_tx byte handshake.
interface solution_framer_if #(
    parameter int MAX_ROWS = 11,
    parameter int MAX_COLS = 11,
    parameter int DIM_W    = $clog2(MAX_ROWS > MAX_COLS ? MAX_ROWS : MAX_COLS)
);
    // valid_in is a one-cycle start pulse that is dropped while busy. send is a one-cycle
    // pulse; byte_out stays stable from send until transmit_done, and a new send is only
    // issued after transmit_done. done pulses once after the final byte is acknowledged.
    logic                         valid_in;
    logic [MAX_ROWS*MAX_COLS-1:0] solution;
    logic [DIM_W-1:0]             m;
    logic [DIM_W-1:0]             n;
    logic                         transmit_done;
    logic                         send;
    logic [7:0]                   byte_out;
    logic                         busy;
    logic                         done;

    modport master (
        output valid_in, solution, m, n, transmit_done,
        input  send, byte_out, busy, done
    );

    modport slave (
        input  valid_in, solution, m, n, transmit_done,
        output send, byte_out, busy, done
    );
endinterface

// File: rtl/solution_framer.sv
// Frames a solved board as HEADER, dims, row-packed cell bytes and an XOR checksum for uart_tx.
module solution_framer #(
    parameter int         MAX_ROWS = 11,
    parameter int         MAX_COLS = 11,
    parameter logic [7:0] HEADER   = 8'hA5,
    parameter int         DIM_W    = $clog2(MAX_ROWS > MAX_COLS ? MAX_ROWS : MAX_COLS)
) (
    input  logic                    clk,
    input  logic                    rst,
    solution_framer_if.slave        bus,
    output logic [1:0]              state_dbg
);
    localparam int SOL_W      = MAX_ROWS * MAX_COLS;
    localparam int MAX_CHUNKS = (MAX_COLS + 7) / 8;
    localparam int CH_W       = $clog2(MAX_CHUNKS + 1);
    localparam int IDX_W      = $clog2(SOL_W);

    typedef enum logic [1:0] {S_IDLE, S_EMIT, S_WAIT, S_FINISH} state_t;
    typedef enum logic [1:0] {P_HDR, P_DIM, P_CELL, P_CSUM} phase_t;

    state_t           state_q, state_d;
    phase_t           phase_q, phase_d;
    logic [DIM_W-1:0] row_q, row_d;
    logic [CH_W-1:0]  chunk_q, chunk_d;
    logic [CH_W-1:0]  nch_q, nch_d;
    logic [DIM_W-1:0] m_q, m_d, n_q, n_d;
    logic [SOL_W-1:0] sol_q, sol_d;
    logic [7:0]       csum_q, csum_d;
    logic [7:0]       byte_q, byte_d;
    logic             send_q, send_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic [DIM_W-1:0] m_clamp, n_clamp;
    logic [7:0]       cell_byte, cur_byte;
    int               col;
    logic [IDX_W-1:0] idx;
    logic [2:0]       bpos;

    assign m_clamp = (bus.m > DIM_W'(MAX_ROWS)) ? DIM_W'(MAX_ROWS) : bus.m;
    assign n_clamp = (bus.n > DIM_W'(MAX_COLS)) ? DIM_W'(MAX_COLS) : bus.n;

    // Bit 7 of each chunk is the leftmost column; columns beyond n pad with zero.
    always_comb begin
        cell_byte = 8'h00;
        col       = 0;
        idx       = '0;
        bpos      = '0;
        for (int j = 0; j < 8; j++) begin
            col = int'(chunk_q) * 8 + j;
            if (col < int'(n_q)) begin
                idx  = IDX_W'(int'(row_q) * MAX_COLS + col);
                bpos = 3'(7 - j);
                cell_byte[bpos] = sol_q[idx];
            end
        end
    end

    always_comb begin
        case (phase_q)
            P_HDR:   cur_byte = HEADER;
            P_DIM:   cur_byte = {4'(m_q), 4'(n_q)};
            P_CELL:  cur_byte = cell_byte;
            default: cur_byte = csum_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        row_d   = row_q;
        chunk_d = chunk_q;
        nch_d   = nch_q;
        m_d     = m_q;
        n_d     = n_q;
        sol_d   = sol_q;
        csum_d  = csum_q;
        byte_d  = byte_q;
        send_d  = 1'b0;
        done_d  = 1'b0;
        busy_d  = busy_q;
        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                // busy is still high during the done cycle, so a pulse there is dropped too.
                if (bus.valid_in && !busy_q) begin
                    sol_d   = bus.solution;
                    m_d     = m_clamp;
                    n_d     = n_clamp;
                    nch_d   = CH_W'((32'(n_clamp) + 32'd7) >> 3);
                    csum_d  = 8'h00;
                    phase_d = P_HDR;
                    row_d   = '0;
                    chunk_d = '0;
                    busy_d  = 1'b1;
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                byte_d = cur_byte;
                send_d = 1'b1;
                if (phase_q != P_CSUM) csum_d = csum_q ^ cur_byte;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.transmit_done) begin
                    state_d = S_EMIT;
                    case (phase_q)
                        P_HDR: phase_d = P_DIM;
                        P_DIM: phase_d = (m_q == '0 || n_q == '0) ? P_CSUM : P_CELL;
                        P_CELL: begin
                            if (chunk_q == nch_q - CH_W'(1)) begin
                                chunk_d = '0;
                                if (row_q == m_q - DIM_W'(1)) phase_d = P_CSUM;
                                else row_d = row_q + DIM_W'(1);
                            end else begin
                                chunk_d = chunk_q + CH_W'(1);
                            end
                        end
                        default: state_d = S_FINISH;
                    endcase
                end
            end
            default: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            phase_q <= P_HDR;
            row_q   <= '0;
            chunk_q <= '0;
            nch_q   <= '0;
            m_q     <= '0;
            n_q     <= '0;
            sol_q   <= '0;
            csum_q  <= 8'h00;
            byte_q  <= 8'h00;
            send_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            row_q   <= row_d;
            chunk_q <= chunk_d;
            nch_q   <= nch_d;
            m_q     <= m_d;
            n_q     <= n_d;
            sol_q   <= sol_d;
            csum_q  <= csum_d;
            byte_q  <= byte_d;
            send_q  <= send_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.send     = send_q;
    assign bus.byte_out = byte_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign state_dbg    = state_q;
endmodule

// File: tb/tb_solution_framer.sv
// Bench for solution_framer: directed and random frames against a byte-list reference model.
module tb_solution_framer;
    localparam int MAX_ROWS = 11;
    localparam int MAX_COLS = 11;
    localparam int DIM_W    = 4;
    localparam int SOL_W    = MAX_ROWS * MAX_COLS;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] state_dbg;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];

    always #10 clk = ~clk;

    solution_framer_if #(.MAX_ROWS(MAX_ROWS), .MAX_COLS(MAX_COLS), .DIM_W(DIM_W)) bus ();

    solution_framer #(.MAX_ROWS(MAX_ROWS), .MAX_COLS(MAX_COLS), .HEADER(8'hA5), .DIM_W(DIM_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [SOL_W-1:0] rand_sol();
        logic [127:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom()};
        return t[SOL_W-1:0];
    endfunction

    // Reference: the frame as a plain list of bytes built from the framing rules.
    function automatic void model_frame(input logic [SOL_W-1:0] sol, input int m, input int n);
        int         mm, nn, cs;
        logic [7:0] b;
        logic [SOL_W-1:0] sh;
        mm = (m > MAX_ROWS) ? MAX_ROWS : m;
        nn = (n > MAX_COLS) ? MAX_COLS : n;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        cs = 'hA5;
        b  = 8'((mm % 16) * 16 + (nn % 16));
        exp_q.push_back(b);
        cs = cs ^ int'(b);
        for (int r = 0; r < mm; r++) begin
            for (int k = 0; k < (nn + 7) / 8; k++) begin
                b = 8'h00;
                for (int j = 0; j < 8; j++) begin
                    if (8 * k + j < nn) begin
                        sh = sol >> (r * MAX_COLS + 8 * k + j);
                        if (sh[0]) b = b | 8'(1 << (7 - j));
                    end
                end
                exp_q.push_back(b);
                cs = cs ^ int'(b);
            end
        end
        exp_q.push_back(8'(cs));
    endfunction

    task automatic start_frame(input logic [SOL_W-1:0] sol, input int m, input int n);
        bus.solution = sol;
        bus.m        = DIM_W'(m);
        bus.n        = DIM_W'(n);
        bus.valid_in = 1'b1;
        tick();
        bus.valid_in = 1'b0;
        // Scramble the inputs after capture; the frame must not follow them.
        bus.solution = rand_sol();
        bus.m        = DIM_W'($urandom_range(0, 15));
        bus.n        = DIM_W'($urandom_range(0, 15));
        check("busy_rise", 32'(bus.busy), 1);
    endtask

    task automatic wait_send(output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            tick();
            cyc++;
            if (bus.send) ok = 1'b1;
        end
    endtask

    // uart_tx stub: acknowledges each byte 10 cycles after its send pulse.
    task automatic run_frame(input int inject_at, input int rst_at);
        int         nb, cyc, stray, dones, overlap;
        bit         ok;
        logic [7:0] e;
        nb = 0;
        wait_send(cyc, ok);
        check("first_send_lat", 32'(cyc), 1);
        while (ok && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            nb++;
            check($sformatf("byte%0d", nb), 32'(bus.byte_out), 32'(e));
            if (nb == rst_at) begin
                repeat (3) tick();
                rst = 1'b1;
                tick();
                rst = 1'b0;
                check("rst_send", 32'(bus.send), 0);
                check("rst_busy", 32'(bus.busy), 0);
                check("rst_byte", 32'(bus.byte_out), 0);
                bus.transmit_done = 1'b1;
                tick();
                bus.transmit_done = 1'b0;
                stray = 0;
                repeat (12) begin
                    tick();
                    if (bus.send) stray++;
                end
                check("rst_no_send", 32'(stray), 0);
                exp_q.delete();
                return;
            end
            if (nb == inject_at) begin
                bus.solution = rand_sol();
                bus.m        = DIM_W'(3);
                bus.n        = DIM_W'(3);
                bus.valid_in = 1'b1;
            end
            stray = 0;
            for (int i = 0; i < 9; i++) begin
                tick();
                bus.valid_in = 1'b0;
                if (bus.send) stray++;
            end
            check("no_stray_send", 32'(stray), 0);
            check("byte_hold", 32'(bus.byte_out), 32'(e));
            bus.transmit_done = 1'b1;
            tick();
            bus.transmit_done = 1'b0;
            if (exp_q.size() > 0) begin
                wait_send(cyc, ok);
                check("td_to_send", 32'(cyc), 1);
            end
        end
        if (!ok) check("send_timeout", 0, 1);
        dones   = 0;
        overlap = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.done) begin
                dones++;
                check("busy_at_done", 32'(bus.busy), 1);
            end
            if (bus.done && bus.send) overlap++;
            if (bus.send) overlap++;
        end
        check("done_count", 32'(dones), 1);
        check("send_after_done", 32'(overlap), 0);
        check("busy_fall", 32'(bus.busy), 0);
    endtask

    task automatic do_frame(input logic [SOL_W-1:0] sol, input int m, input int n,
                            input int inject_at, input int rst_at);
        model_frame(sol, m, n);
        start_frame(sol, m, n);
        run_frame(inject_at, rst_at);
    endtask

    initial begin
        logic [SOL_W-1:0] sol;
        int stray;
        rst               = 1'b1;
        bus.valid_in      = 1'b0;
        bus.solution      = '0;
        bus.m             = '0;
        bus.n             = '0;
        bus.transmit_done = 1'b0;
        repeat (3) tick();
        check("reset_send", 32'(bus.send), 0);
        check("reset_done", 32'(bus.done), 0);
        check("reset_busy", 32'(bus.busy), 0);
        check("reset_byte", 32'(bus.byte_out), 0);
        rst = 1'b0;
        tick();

        // transmit_done while idle must not start anything
        bus.transmit_done = 1'b1;
        tick();
        bus.transmit_done = 1'b0;
        stray = 0;
        repeat (5) begin
            tick();
            if (bus.send || bus.busy) stray++;
        end
        check("idle_td_ignored", 32'(stray), 0);

        do_frame('0, 11, 11, 0, 0);
        do_frame({SOL_W{1'b1}}, 11, 11, 0, 0);
        sol = '0; sol[0] = 1'b1;
        do_frame(sol, 11, 11, 0, 0);
        sol = '0; sol[15:11] = 5'b11111;
        do_frame(sol, 3, 5, 0, 0);

        do_frame(rand_sol(), 11, 11, 5, 0);
        do_frame(rand_sol(), 7, 9, 0, 0);
        do_frame(rand_sol(), 11, 11, 0, 4);
        do_frame(rand_sol(), 11, 11, 0, 0);

        do_frame(rand_sol(), 15, 13, 0, 0);
        do_frame(rand_sol(), 0, 7, 0, 0);
        do_frame(rand_sol(), 5, 0, 0, 0);
        for (int t = 0; t < 6; t++)
            do_frame(rand_sol(), $urandom_range(0, 15), $urandom_range(0, 15), 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
